// File: rtl/id_operand_stage_pkg.sv
// Types shared between the ID forward-select unit and the ID operand stage.
package id_operand_stage_pkg;
  localparam int OPERAND_W = 32;

  typedef enum logic [2:0] {
    FWD_RF   = 3'd0,
    FWD_EXE  = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_MEM2 = 3'd3,
    FWD_WB   = 3'd4
  } fwd_sel_e;
endpackage

// File: rtl/id_operand_stage_operand_hold_mux.sv
// One operand: bypass mux, producer readiness check and a hold latch that
// freezes the resolved value while ID waits on the other operand or on EXE.
module operand_hold_mux
  import id_operand_stage_pkg::*;
#(
  parameter int DW = OPERAND_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [2:0]    i_sel,
  input  logic [DW-1:0] i_rf,
  input  logic [DW-1:0] i_exe,
  input  logic [DW-1:0] i_mem,
  input  logic [DW-1:0] i_mem2,
  input  logic [DW-1:0] i_wb,
  input  logic          i_exe_ok,
  input  logic          i_mem_ok,
  input  logic          i_mem2_ok,
  input  logic          i_id_valid,
  input  logic          i_fire,
  input  logic          i_flush,
  output logic [DW-1:0] o_value,
  output logic          o_ok
);
  logic [DW-1:0] w_mux;
  logic          w_ready;
  logic [DW-1:0] r_hold;
  logic          r_hold_v;

  // Encodings 5-7 are not produced by the forward unit; read them as RF.
  always_comb begin
    w_mux   = i_rf;
    w_ready = 1'b1;
    case (i_sel)
      FWD_EXE:  begin w_mux = i_exe;  w_ready = i_exe_ok;  end
      FWD_MEM:  begin w_mux = i_mem;  w_ready = i_mem_ok;  end
      FWD_MEM2: begin w_mux = i_mem2; w_ready = i_mem2_ok; end
      FWD_WB:   begin w_mux = i_wb;   w_ready = 1'b1;      end
      default:  begin w_mux = i_rf;   w_ready = 1'b1;      end
    endcase
  end

  assign o_value = r_hold_v ? r_hold : w_mux;
  assign o_ok    = r_hold_v | w_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
    end else if (i_flush || i_fire) begin
      r_hold_v <= 1'b0;
    end else if (i_id_valid && w_ready && !r_hold_v) begin
      r_hold   <= w_mux;
      r_hold_v <= 1'b1;
    end
  end
endmodule

// File: rtl/id_operand_stage.sv
// ID-stage operand resolution with load-use stall and the ID/EXE pipeline
// register, handshaked to EXE through valid/allowin.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DW = OPERAND_W,
  parameter int PW = 64,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_id_valid,
  input  logic [PW-1:0] i_id_payload,
  input  logic [2:0]    i_fwd_a,
  input  logic [2:0]    i_fwd_b,
  input  logic [DW-1:0] i_rf_rdata1,
  input  logic [DW-1:0] i_rf_rdata2,
  input  logic [DW-1:0] i_exe_result,
  input  logic [DW-1:0] i_mem_result,
  input  logic [DW-1:0] i_mem2_result,
  input  logic [DW-1:0] i_wb_result,
  input  logic          i_exe_res_ok,
  input  logic          i_mem_res_ok,
  input  logic          i_mem2_res_ok,
  input  logic          i_flush,
  input  logic          i_exe_allowin,
  output logic          o_id_allowin,
  output logic          o_ex_valid,
  output logic [DW-1:0] o_ex_src_a,
  output logic [DW-1:0] o_ex_src_b,
  output logic [PW-1:0] o_ex_payload,
  output logic [CW-1:0] o_stall_cycles
);
  logic [DW-1:0] w_val_a, w_val_b;
  logic          w_ok_a, w_ok_b;
  logic          w_out_allowin, w_fire, w_stall;

  logic          r_ex_valid;
  logic [DW-1:0] r_ex_src_a, r_ex_src_b;
  logic [PW-1:0] r_ex_payload;
  logic [CW-1:0] r_stall_cycles;

  operand_hold_mux #(.DW(DW)) u_op_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_sel(i_fwd_a),
    .i_rf(i_rf_rdata1), .i_exe(i_exe_result), .i_mem(i_mem_result),
    .i_mem2(i_mem2_result), .i_wb(i_wb_result),
    .i_exe_ok(i_exe_res_ok), .i_mem_ok(i_mem_res_ok), .i_mem2_ok(i_mem2_res_ok),
    .i_id_valid(i_id_valid), .i_fire(w_fire), .i_flush(i_flush),
    .o_value(w_val_a), .o_ok(w_ok_a)
  );

  operand_hold_mux #(.DW(DW)) u_op_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_sel(i_fwd_b),
    .i_rf(i_rf_rdata2), .i_exe(i_exe_result), .i_mem(i_mem_result),
    .i_mem2(i_mem2_result), .i_wb(i_wb_result),
    .i_exe_ok(i_exe_res_ok), .i_mem_ok(i_mem_res_ok), .i_mem2_ok(i_mem2_res_ok),
    .i_id_valid(i_id_valid), .i_fire(w_fire), .i_flush(i_flush),
    .o_value(w_val_b), .o_ok(w_ok_b)
  );

  assign w_out_allowin = !r_ex_valid || i_exe_allowin;
  assign w_fire        = i_id_valid && w_ok_a && w_ok_b && w_out_allowin && !i_flush;
  assign w_stall       = i_id_valid && !i_flush && !(w_ok_a && w_ok_b);
  assign o_id_allowin  = !i_id_valid || w_fire;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_src_a   <= '0;
      r_ex_src_b   <= '0;
      r_ex_payload <= '0;
    end else if (i_flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_fire) begin
      r_ex_valid   <= 1'b1;
      r_ex_src_a   <= w_val_a;
      r_ex_src_b   <= w_val_b;
      r_ex_payload <= i_id_payload;
    end else if (i_exe_allowin) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Statistics only; flush deliberately leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + CW'(1);
    end
  end

  assign o_ex_valid     = r_ex_valid;
  assign o_ex_src_a     = r_ex_src_a;
  assign o_ex_src_b     = r_ex_src_b;
  assign o_ex_payload   = r_ex_payload;
  assign o_stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: vector table for mux/forwarding plus
// hand-written stall, hold, flush and saturation sequences.
module tb_id_operand_stage;
  localparam int DW = 32;
  localparam int PW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [PW-1:0] id_payload;
  logic [2:0]    fwd_a, fwd_b;
  logic [DW-1:0] rf1, rf2, exe_r, mem_r, mem2_r, wb_r;
  logic          exe_ok, mem_ok, mem2_ok, flush, exe_allowin;
  logic          id_allowin, ex_valid;
  logic [DW-1:0] ex_src_a, ex_src_b;
  logic [PW-1:0] ex_payload;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_operand_stage #(.DW(DW), .PW(PW), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_payload(id_payload),
    .i_fwd_a(fwd_a), .i_fwd_b(fwd_b), .i_rf_rdata1(rf1), .i_rf_rdata2(rf2),
    .i_exe_result(exe_r), .i_mem_result(mem_r), .i_mem2_result(mem2_r),
    .i_wb_result(wb_r), .i_exe_res_ok(exe_ok), .i_mem_res_ok(mem_ok),
    .i_mem2_res_ok(mem2_ok), .i_flush(flush), .i_exe_allowin(exe_allowin),
    .o_id_allowin(id_allowin), .o_ex_valid(ex_valid), .o_ex_src_a(ex_src_a),
    .o_ex_src_b(ex_src_b), .o_ex_payload(ex_payload), .o_stall_cycles(stall_cycles)
  );

  typedef struct {
    logic [2:0]    sa, sb;
    logic          eok, mok, m2ok;
    logic [DW-1:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_payload = '0; fwd_a = 0; fwd_b = 0;
    rf1 = 0; rf2 = 0; exe_r = 0; mem_r = 0; mem2_r = 0; wb_r = 0;
    exe_ok = 0; mem_ok = 0; mem2_ok = 0; flush = 0; exe_allowin = 0;
    #1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_src_a", 64'(ex_src_a), 64'd0);
    chk("rst_src_b", 64'(ex_src_b), 64'd0);
    chk("rst_payload", ex_payload, 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_allowin", 64'(id_allowin), 64'd1);

    // Sustained RF traffic: one instruction per cycle.
    exe_allowin = 1; id_valid = 1;
    for (int i = 0; i < 8; i++) begin
      rf1 = 32'h11 + 32'(i); rf2 = 32'h22 + 32'(i); id_payload = 64'(i) + 64'h500;
      #1;
      chk("rf_allowin", 64'(id_allowin), 64'd1);
      step();
      chk("rf_valid", 64'(ex_valid), 64'd1);
      chk("rf_src_a", 64'(ex_src_a), 64'h11 + 64'(i));
      chk("rf_src_b", 64'(ex_src_b), 64'h22 + 64'(i));
      chk("rf_payload", ex_payload, 64'(i) + 64'h500);
    end
    id_valid = 0;
    step();
    chk("drain_valid", 64'(ex_valid), 64'd0);

    // Forwarding vectors: every entry resolves and fires.
    vecs[0] = '{3'd1, 3'd2, 1, 1, 1, 32'hE0, 32'hC0};
    vecs[1] = '{3'd3, 3'd4, 1, 1, 1, 32'hC2, 32'hF4};
    vecs[2] = '{3'd5, 3'd7, 1, 1, 1, 32'hA1, 32'hB2};
    vecs[3] = '{3'd6, 3'd0, 0, 0, 0, 32'hA1, 32'hB2};
    vecs[4] = '{3'd4, 3'd1, 1, 1, 1, 32'hF4, 32'hE0};
    vecs[5] = '{3'd2, 3'd3, 0, 1, 1, 32'hC0, 32'hC2};
    vecs[6] = '{3'd4, 3'd0, 0, 0, 0, 32'hF4, 32'hB2};
    rf1 = 32'hA1; rf2 = 32'hB2; exe_r = 32'hE0; mem_r = 32'hC0;
    mem2_r = 32'hC2; wb_r = 32'hF4;
    for (int i = 0; i < 7; i++) begin
      fwd_a = vecs[i].sa; fwd_b = vecs[i].sb;
      exe_ok = vecs[i].eok; mem_ok = vecs[i].mok; mem2_ok = vecs[i].m2ok;
      id_payload = 64'h100 + 64'(i); id_valid = 1;
      #1;
      chk("vec_allowin", 64'(id_allowin), 64'd1);
      step();
      chk("vec_valid", 64'(ex_valid), 64'd1);
      chk("vec_src_a", 64'(ex_src_a), 64'(vecs[i].exp_a));
      chk("vec_src_b", 64'(ex_src_b), 64'(vecs[i].exp_b));
    end
    id_valid = 0; fwd_a = 0; fwd_b = 0;
    chk("vec_stall_none", 64'(stall_cycles), 64'd0);

    // Load-use: EXE value not final for two cycles.
    do_reset();
    id_valid = 1; fwd_a = 3'd1; fwd_b = 3'd0; exe_ok = 0; exe_allowin = 1;
    rf2 = 32'h22; exe_r = 32'h1234; id_payload = 64'hAB;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lu_allowin_low", 64'(id_allowin), 64'd0);
      step();
      chk("lu_no_fire", 64'(ex_valid), 64'd0);
    end
    exe_ok = 1; exe_r = 32'hDEAD;
    #1;
    chk("lu_allowin_rel", 64'(id_allowin), 64'd1);
    chk("lu_stall", 64'(stall_cycles), 64'd2);
    step();
    chk("lu_valid", 64'(ex_valid), 64'd1);
    chk("lu_src_a", 64'(ex_src_a), 64'hDEAD);
    chk("lu_src_b", 64'(ex_src_b), 64'h22);
    chk("lu_stall_after", 64'(stall_cycles), 64'd2);
    id_valid = 0;
    step();

    // Hold: operands latched while EXE blocked; producer then advances.
    do_reset();
    id_valid = 1; fwd_a = 0; fwd_b = 0; rf1 = 32'h1; rf2 = 32'h2;
    exe_allowin = 1; id_payload = 64'hA0;
    step();
    chk("hold_first", 64'(ex_valid), 64'd1);
    exe_allowin = 0; id_payload = 64'hA1; rf1 = 32'h77;
    fwd_b = 3'd3; mem2_r = 32'h55; mem2_ok = 1;
    #1;
    chk("hold_blocked", 64'(id_allowin), 64'd0);
    step();
    chk("hold_keep_b", 64'(ex_src_b), 64'h2);
    chk("hold_keep_valid", 64'(ex_valid), 64'd1);
    fwd_b = 3'd4; wb_r = 32'h99; mem2_r = 32'hAA; rf1 = 32'h12;
    step();
    exe_allowin = 1;
    #1;
    chk("hold_allowin", 64'(id_allowin), 64'd1);
    step();
    chk("hold_src_b", 64'(ex_src_b), 64'h55);
    chk("hold_src_a", 64'(ex_src_a), 64'h77);
    chk("hold_payload", ex_payload, 64'hA1);
    chk("hold_stall", 64'(stall_cycles), 64'd0);
    id_valid = 0;
    step();

    // Flush while stalled with operand a held.
    do_reset();
    id_valid = 1; fwd_a = 0; fwd_b = 0; rf1 = 32'h3; rf2 = 32'h4;
    exe_allowin = 1; id_payload = 64'hB0;
    step();
    exe_allowin = 0; rf1 = 32'h31; fwd_b = 3'd1; exe_ok = 0; id_payload = 64'hB1;
    step();
    rf1 = 32'h41;
    step();
    chk("fl_stall_pre", 64'(stall_cycles), 64'd2);
    flush = 1;
    #1;
    chk("fl_allowin", 64'(id_allowin), 64'd0);
    step();
    flush = 0;
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_stall_kept", 64'(stall_cycles), 64'd2);
    fwd_b = 0; rf1 = 32'h51; rf2 = 32'h52; exe_allowin = 1; id_payload = 64'hB2;
    #1;
    chk("fl_allowin_new", 64'(id_allowin), 64'd1);
    step();
    chk("fl_new_valid", 64'(ex_valid), 64'd1);
    chk("fl_new_a", 64'(ex_src_a), 64'h51);
    chk("fl_new_b", 64'(ex_src_b), 64'h52);
    chk("fl_new_payload", ex_payload, 64'hB2);
    id_valid = 0;
    step();

    // id_valid low: no count even with a not-ready select.
    do_reset();
    fwd_a = 3'd1; exe_ok = 0; id_valid = 0;
    step(); step(); step();
    chk("idle_stall", 64'(stall_cycles), 64'd0);
    chk("idle_allowin", 64'(id_allowin), 64'd1);

    // Saturation at 15, then reset mid-stall.
    id_valid = 1;
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", 64'(stall_cycles), 64'd14);
    for (int i = 0; i < 6; i++) step();
    chk("sat_15", 64'(stall_cycles), 64'd15);
    rst = 1;
    step();
    chk("midrst_stall", 64'(stall_cycles), 64'd0);
    chk("midrst_valid", 64'(ex_valid), 64'd0);
    rst = 0; exe_ok = 1; exe_r = 32'h66; fwd_b = 0; rf2 = 32'h67;
    step();
    chk("midrst_fire_a", 64'(ex_src_a), 64'h66);
    id_valid = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
